// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the single-port memory controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_WR     = 3'd2,
    ST_RD     = 3'd3,
    ST_RD_CAP = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  // One extra count past the last word so the counter never wraps when
  // MEM_DEPTH fills the whole address space.
  function automatic int init_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Zero-fill address counter and sticky completion flag for the INIT phase.
module mem_init_seq
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = 8,
  parameter bit INIT_EN   = 1'b1,
  localparam int CNT_W    = init_cnt_width(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             done
);

  assign last = (cnt == CNT_W'(MEM_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= ~INIT_EN;
    end else if (run) begin
      if (last) begin
        done <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Initiator-side controller for a single-port synchronous memory: zero-fill
// after reset, then one request/response transaction at a time.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 8,
  parameter int MEM_WIDTH  = 16,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [MEM_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MEM_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done,
  output logic                  oor_err,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_wdata,
  input  logic [MEM_WIDTH-1:0]  mem_rdata
);

  localparam int CNT_W = init_cnt_width(MEM_DEPTH);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        init_cnt;
  logic                    init_last;
  logic                    init_run;
  logic                    in_range;

  logic                    mem_wr_en_nxt;
  logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
  logic [MEM_WIDTH-1:0]    mem_wdata_nxt;
  logic                    rsp_valid_nxt;
  logic [MEM_WIDTH-1:0]    rsp_rdata_nxt;
  logic                    rsp_err_nxt;
  logic                    oor_err_nxt;

  assign init_run  = (state == ST_INIT);
  assign req_ready = (state == ST_IDLE);

  // Widened by one bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
  assign in_range = ({1'b0, req_addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH));

  mem_init_seq #(
    .MEM_DEPTH (MEM_DEPTH),
    .INIT_EN   (INIT_EN)
  ) u_init_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (init_run),
    .cnt   (init_cnt),
    .last  (init_last),
    .done  (init_done)
  );

  always_comb begin
    state_nxt     = state;
    mem_wr_en_nxt = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    oor_err_nxt   = oor_err;

    case (state)
      ST_INIT: begin
        if (init_last) begin
          state_nxt = ST_IDLE;
        end else begin
          mem_wr_en_nxt = 1'b1;
          mem_addr_nxt  = ADDR_WIDTH'(init_cnt);
          mem_wdata_nxt = '0;
        end
      end

      ST_IDLE: begin
        if (req_valid) begin
          if (in_range) begin
            mem_addr_nxt = req_addr;
            if (req_wr) begin
              mem_wr_en_nxt = 1'b1;
              mem_wdata_nxt = req_wdata;
              state_nxt     = ST_WR;
            end else begin
              state_nxt = ST_RD;
            end
          end else begin
            // Out-of-range: never touch the memory; reads still get an
            // error response so the consumer is not left waiting.
            oor_err_nxt = 1'b1;
            if (!req_wr) begin
              rsp_valid_nxt = 1'b1;
              rsp_err_nxt   = 1'b1;
              rsp_rdata_nxt = '0;
              state_nxt     = ST_RESP;
            end
          end
        end
      end

      ST_WR: begin
        state_nxt = ST_IDLE;
      end

      ST_RD: begin
        state_nxt = ST_RD_CAP;
      end

      ST_RD_CAP: begin
        rsp_rdata_nxt = mem_rdata;
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = 1'b0;
        state_nxt     = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT_EN ? ST_INIT : ST_IDLE;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      oor_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_wr_en <= mem_wr_en_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      oor_err   <= oor_err_nxt;
    end
  end

endmodule
